// File: rtl/regfile_param.sv
// Parameterised register file: two registered read ports, one write port,
// per-register pending (lock) bits with optional write-to-read bypass.

module regfile_param_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic             set,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             pend
);
    logic [WIDTH-1:0] data_d, data_q;
    logic             pend_d, pend_q;

    always_comb begin
        data_d = we ? wd : data_q;
        pend_d = pend_q;
        if (clr) pend_d = 1'b0;
        // set is applied last so a same-edge lock beats the clearing write
        if (set) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

    assign q    = data_q;
    assign pend = pend_q;
endmodule

module regfile_param #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1,
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] AA,
    input  logic [ADDR_W-1:0] BA,
    input  logic              RE,
    input  logic [ADDR_W-1:0] DA,
    input  logic [WIDTH-1:0]  DD,
    input  logic              RW,
    input  logic              LK,
    input  logic [ADDR_W-1:0] LA,
    output logic [WIDTH-1:0]  AD,
    output logic [WIDTH-1:0]  BD,
    output logic              RV,
    output logic              AP,
    output logic              BP,
    output logic [DEPTH-1:0]  PEND
);
    logic [DEPTH-1:0][WIDTH-1:0] reg_q;
    logic [DEPTH-1:0]            pend_q;
    logic                        wr_en, lk_en;

    // register 0 is hard-wired to zero when ZERO_R0 is set
    assign wr_en = RW && !(ZERO_R0 != 0 && DA == '0);
    assign lk_en = LK && !(ZERO_R0 != 0 && LA == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        regfile_param_cell #(.WIDTH(WIDTH)) u_cell (
            .clk  (CLK),
            .rst  (RESET),
            .we   (wr_en && DA == ADDR_W'(i)),
            .wd   (DD),
            .set  (lk_en && LA == ADDR_W'(i)),
            .clr  (RW && DA == ADDR_W'(i)),
            .q    (reg_q[i]),
            .pend (pend_q[i])
        );
    end

    function automatic logic [WIDTH:0] read_port(
        input logic [ADDR_W-1:0]            a,
        input logic [DEPTH-1:0][WIDTH-1:0]  regs,
        input logic [DEPTH-1:0]             pends,
        input logic                         we,
        input logic [ADDR_W-1:0]            wa,
        input logic [WIDTH-1:0]             wd,
        input logic                         lk,
        input logic [ADDR_W-1:0]            la
    );
        logic [WIDTH-1:0] d;
        logic             p;
        d = regs[a];
        p = pends[a];
        if (BYPASS != 0 && we && wa == a) begin
            d = wd;
            p = lk && la == a;
        end
        if (ZERO_R0 != 0 && a == '0) begin
            d = '0;
            p = 1'b0;
        end
        return {p, d};
    endfunction

    logic [WIDTH-1:0] ad_d, ad_q, bd_d, bd_q;
    logic             ap_d, ap_q, bp_d, bp_q, rv_d, rv_q;
    logic [WIDTH:0]   port_a, port_b;

    always_comb begin
        port_a = read_port(AA, reg_q, pend_q, wr_en, DA, DD, lk_en, LA);
        port_b = read_port(BA, reg_q, pend_q, wr_en, DA, DD, lk_en, LA);
        ad_d   = ad_q;
        bd_d   = bd_q;
        ap_d   = ap_q;
        bp_d   = bp_q;
        rv_d   = RE;
        if (RE) begin
            ad_d = port_a[WIDTH-1:0];
            ap_d = port_a[WIDTH];
            bd_d = port_b[WIDTH-1:0];
            bp_d = port_b[WIDTH];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ad_q <= '0;
            bd_q <= '0;
            ap_q <= 1'b0;
            bp_q <= 1'b0;
            rv_q <= 1'b0;
        end else begin
            ad_q <= ad_d;
            bd_q <= bd_d;
            ap_q <= ap_d;
            bp_q <= bp_d;
            rv_q <= rv_d;
        end
    end

    assign AD   = ad_q;
    assign BD   = bd_q;
    assign AP   = ap_q;
    assign BP   = bp_q;
    assign RV   = rv_q;
    assign PEND = pend_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (default, no-bypass, zero-r0) share
// stimulus; vectors go through a scoreboard queue, corner cases are hand-driven.

module tb_regfile_param;
    logic        CLK, RESET, RE, RW, LK;
    logic [2:0]  AA, BA, DA, LA;
    logic [15:0] DD;

    logic [15:0] ad_m, bd_m, ad_n, bd_n, ad_z, bd_z;
    logic        rv_m, ap_m, bp_m, rv_n, ap_n, bp_n, rv_z, ap_z, bp_z;
    logic [7:0]  pend_m, pend_n, pend_z;

    regfile_param dut (
        .CLK(CLK), .RESET(RESET), .AA(AA), .BA(BA), .RE(RE), .DA(DA), .DD(DD),
        .RW(RW), .LK(LK), .LA(LA), .AD(ad_m), .BD(bd_m), .RV(rv_m), .AP(ap_m),
        .BP(bp_m), .PEND(pend_m));

    regfile_param #(.BYPASS(0)) dut_nb (
        .CLK(CLK), .RESET(RESET), .AA(AA), .BA(BA), .RE(RE), .DA(DA), .DD(DD),
        .RW(RW), .LK(LK), .LA(LA), .AD(ad_n), .BD(bd_n), .RV(rv_n), .AP(ap_n),
        .BP(bp_n), .PEND(pend_n));

    regfile_param #(.ZERO_R0(1)) dut_z (
        .CLK(CLK), .RESET(RESET), .AA(AA), .BA(BA), .RE(RE), .DA(DA), .DD(DD),
        .RW(RW), .LK(LK), .LA(LA), .AD(ad_z), .BD(bd_z), .RV(rv_z), .AP(ap_z),
        .BP(bp_z), .PEND(pend_z));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rw;
        logic [2:0]  da;
        logic [15:0] dd;
        logic        re;
        logic [2:0]  aa, ba;
        logic        lk;
        logic [2:0]  la;
        logic [15:0] ad, bd;
        logic        rv, ap, bp;
        logic [7:0]  pend;
        logic [15:0] nb_ad;
        logic        nb_ap;
        logic [15:0] z_ad;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic rw, input logic [2:0] da, input logic [15:0] dd,
                         input logic re, input logic [2:0] aa, input logic [2:0] ba,
                         input logic lk, input logic [2:0] la);
        @(negedge CLK);
        RW = rw; DA = da; DD = dd; RE = re; AA = aa; BA = ba; LK = lk; LA = la;
    endtask

    function automatic vec_t mk(
        input string nm, input logic rw, input logic [2:0] da, input logic [15:0] dd,
        input logic re, input logic [2:0] aa, input logic [2:0] ba,
        input logic lk, input logic [2:0] la,
        input logic [15:0] ad, input logic [15:0] bd, input logic rv,
        input logic ap, input logic bp, input logic [7:0] pend,
        input logic [15:0] nb_ad, input logic nb_ap, input logic [15:0] z_ad);
        vec_t v;
        v.name = nm; v.rw = rw; v.da = da; v.dd = dd; v.re = re; v.aa = aa; v.ba = ba;
        v.lk = lk; v.la = la; v.ad = ad; v.bd = bd; v.rv = rv; v.ap = ap; v.bp = bp;
        v.pend = pend; v.nb_ad = nb_ad; v.nb_ap = nb_ap; v.z_ad = z_ad;
        return v;
    endfunction

    initial begin
        vec_t e;
        //          name          rw da dd        re aa ba lk la  AD        BD        RV AP BP PEND   nbAD      nbAP zAD
        vecs[0]  = mk("wr3",      1, 3, 16'hA5A5, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h0000);
        vecs[1]  = mk("rd3_0",    0, 0, 16'h0000, 1, 3, 0, 0, 0, 16'hA5A5, 16'h0000, 1, 0, 0, 8'h00, 16'hA5A5, 0, 16'hA5A5);
        vecs[2]  = mk("byp5",     1, 5, 16'h1234, 1, 5, 3, 0, 0, 16'h1234, 16'hA5A5, 1, 0, 0, 8'h00, 16'h0000, 0, 16'h1234);
        vecs[3]  = mk("hold",     0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h1234, 16'hA5A5, 0, 0, 0, 8'h00, 16'h0000, 0, 16'h1234);
        vecs[4]  = mk("lock2",    0, 0, 16'h0000, 0, 0, 0, 1, 2, 16'h1234, 16'hA5A5, 0, 0, 0, 8'h04, 16'h0000, 0, 16'h1234);
        vecs[5]  = mk("rd_pend2", 0, 0, 16'h0000, 1, 2, 2, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 8'h04, 16'h0000, 1, 16'h0000);
        vecs[6]  = mk("wr2_clr",  1, 2, 16'h0F0F, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 8'h00, 16'h0000, 1, 16'h0000);
        vecs[7]  = mk("rd2_5",    0, 0, 16'h0000, 1, 2, 5, 0, 0, 16'h0F0F, 16'h1234, 1, 0, 0, 8'h00, 16'h0F0F, 0, 16'h0F0F);
        vecs[8]  = mk("lkwr6",    1, 6, 16'hBEEF, 0, 0, 0, 1, 6, 16'h0F0F, 16'h1234, 0, 0, 0, 8'h40, 16'h0F0F, 0, 16'h0F0F);
        vecs[9]  = mk("rd6_lk7",  0, 0, 16'h0000, 1, 6, 7, 1, 7, 16'hBEEF, 16'h0000, 1, 1, 0, 8'hC0, 16'hBEEF, 1, 16'hBEEF);
        vecs[10] = mk("byp7_lk",  1, 7, 16'h7777, 1, 7, 6, 1, 7, 16'h7777, 16'hBEEF, 1, 1, 1, 8'hC0, 16'h0000, 1, 16'h7777);
        vecs[11] = mk("byp6_clr", 1, 6, 16'h1111, 1, 6, 6, 0, 0, 16'h1111, 16'h1111, 1, 0, 0, 8'h80, 16'hBEEF, 1, 16'h1111);
        vecs[12] = mk("byp0",     1, 0, 16'h00AA, 1, 0, 0, 0, 0, 16'h00AA, 16'h00AA, 1, 0, 0, 8'h80, 16'h0000, 0, 16'h0000);

        RESET = 1'b1; RW = 0; DA = 0; DD = 0; RE = 0; AA = 0; BA = 0; LK = 0; LA = 0;
        #1;
        chk("rst_ad", 32'(ad_m), 32'h0);
        chk("rst_bd", 32'(bd_m), 32'h0);
        chk("rst_rv", 32'(rv_m), 32'h0);
        chk("rst_pend", 32'(pend_m), 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rw, vecs[i].da, vecs[i].dd, vecs[i].re, vecs[i].aa, vecs[i].ba,
                  vecs[i].lk, vecs[i].la);
            sb.push_back(vecs[i]);
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            chk({e.name, ".AD"}, 32'(ad_m), 32'(e.ad));
            chk({e.name, ".BD"}, 32'(bd_m), 32'(e.bd));
            chk({e.name, ".RV"}, 32'(rv_m), 32'(e.rv));
            chk({e.name, ".AP"}, 32'(ap_m), 32'(e.ap));
            chk({e.name, ".BP"}, 32'(bp_m), 32'(e.bp));
            chk({e.name, ".PEND"}, 32'(pend_m), 32'(e.pend));
            chk({e.name, ".nb_AD"}, 32'(ad_n), 32'(e.nb_ad));
            chk({e.name, ".nb_AP"}, 32'(ap_n), 32'(e.nb_ap));
            chk({e.name, ".z_AD"}, 32'(ad_z), 32'(e.z_ad));
        end

        // zero-register: write and lock of R0 have no effect
        drive(1, 0, 16'hFFFF, 0, 0, 0, 1, 0);
        @(posedge CLK); #1;
        chk("r0_z_pend", 32'(pend_z), 32'h80);
        chk("r0_m_pend", 32'(pend_m), 32'h81);
        drive(0, 0, 16'h0000, 1, 0, 0, 0, 0);
        @(posedge CLK); #1;
        chk("r0_z_ad", 32'(ad_z), 32'h0);
        chk("r0_z_ap", 32'(ap_z), 32'h0);
        chk("r0_m_ad", 32'(ad_m), 32'hFFFF);
        chk("r0_m_ap", 32'(ap_m), 32'h1);

        // mid-cycle reset
        drive(1, 1, 16'h0001, 0, 0, 0, 1, 4);
        @(posedge CLK); #1;
        chk("pre_rst_pend", 32'(pend_m), 32'h91);
        drive(0, 0, 16'h0000, 1, 1, 4, 0, 0);
        @(posedge CLK); #1;
        chk("pre_rst_ad", 32'(ad_m), 32'h0001);
        chk("pre_rst_bp", 32'(bp_m), 32'h1);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_ad", 32'(ad_m), 32'h0);
        chk("mid_rst_bd", 32'(bd_m), 32'h0);
        chk("mid_rst_pend", 32'(pend_m), 32'h0);
        chk("mid_rst_rv", 32'(rv_m), 32'h0);
        // activity while held in reset must be discarded
        drive(1, 1, 16'hDEAD, 1, 1, 1, 1, 3);
        @(posedge CLK); #1;
        chk("in_rst_rv", 32'(rv_m), 32'h0);
        chk("in_rst_pend", 32'(pend_m), 32'h0);
        drive(0, 0, 16'h0000, 1, 1, 3, 0, 0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_ad", 32'(ad_m), 32'h0);
        chk("post_rst_bd", 32'(bd_m), 32'h0);
        chk("post_rst_rv", 32'(rv_m), 32'h1);
        chk("post_rst_bp", 32'(bp_m), 32'h0);
        chk("post_rst_pend", 32'(pend_m), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 16: data width of each register and each data port, in bits.
REQ-002 Parameter ADDR_W, default 3: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_R0, default 0: when 1, register 0 reads as zero and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a same-edge write is forwarded to the read ports.
REQ-005 CLK  input  1  clock; all state updates on the rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 AA  input  ADDR_W  read port A address.
REQ-008 BA  input  ADDR_W  read port B address.
REQ-009 RE  input  1  read request; samples AA/BA on this edge.
REQ-010 DA  input  ADDR_W  write address.
REQ-011 DD  input  WIDTH  write data.
REQ-012 RW  input  1  write enable.
REQ-013 LK  input  1  lock request; marks register LA as pending.
REQ-014 LA  input  ADDR_W  lock address.
REQ-015 AD  output  WIDTH  registered port A read data.
REQ-016 BD  output  WIDTH  registered port B read data.
REQ-017 RV  output  1  AD/BD/AP/BP valid, one cycle wide per accepted RE.
REQ-018 AP  output  1  port A register was pending when sampled.
REQ-019 BP  output  1  port B register was pending when sampled.
REQ-020 PEND  output  DEPTH  live pending-bit vector, bit i = register i.

Function
REQ-021 Storage SHALL be DEPTH registers of WIDTH bits, plus a DEPTH-bit pending vector.
REQ-022 On a rising edge with RW=1, R[DA] SHALL take DD; exception: DA=0 with ZERO_R0=1 SHALL write nothing.
REQ-023 Reads SHALL have 1-cycle latency: RE=1 at edge N gives AD=R[AA], BD=R[BA] and RV=1 after edge N.
REQ-024 AD, BD, AP and BP SHALL hold their values while RE=0; RV SHALL be 0 after any edge with RE=0.
REQ-025 BYPASS=1 and RW=1 with DA=AA on the same edge as RE=1: AD SHALL take DD; likewise BD when DA=BA.
REQ-026 BYPASS=0 in the same situation: AD/BD SHALL take the pre-write register contents.
REQ-027 ZERO_R0=1: a read of address 0 SHALL return 0 and SHALL report AP/BP=0, including under bypass.
REQ-028 LK=1 SHALL set PEND[LA] on the edge; LK is ignored for LA=0 when ZERO_R0=1.
REQ-029 RW=1 SHALL clear PEND[DA] on the edge.
REQ-030 LK=1 and RW=1 with LA=DA on the same edge: set SHALL win, so PEND[LA]=1 afterwards.
REQ-031 AP SHALL be PEND[AA] as sampled at the RE edge; when BYPASS=1 and a same-edge write to AA occurs, AP SHALL be 0 unless a same-edge lock to AA also occurs. BP SHALL follow the same rule for BA.
REQ-032 A lock issued on the same edge as RE SHALL NOT set AP/BP for that read (pre-edge PEND is used), apart from the REQ-031 case.
REQ-033 AA=BA SHALL return identical data on both ports; all address values are legal, with no wrap or range checks.
REQ-034 PEND SHALL be a direct register output with no combinational path from inputs.

Reset
REQ-035 While RESET=1: all R[i]=0, PEND=0, AD=0, BD=0, RV=0, AP=0, BP=0, independent of CLK.
REQ-036 RESET asserted mid-operation SHALL discard any same-edge write, lock or read; the first edge after deassertion operates normally.

Verification
REQ-037 Reset, then RW=1 DA=3 DD=16'hA5A5, then RE=1 AA=3 BA=0 -> next cycle AD=16'hA5A5, BD=0, RV=1, AP=BP=0.
REQ-038 BYPASS=1: same edge RW=1 DA=5 DD=16'h1234, RE=1 AA=5 -> AD=16'h1234. Repeat with BYPASS=0 -> AD=0.
REQ-039 LK=1 LA=2, then RE=1 AA=2 -> AP=1 and PEND=8'h04. Then RW=1 DA=2 DD=16'h0F0F -> PEND=0; a following read gives AP=0 and AD=16'h0F0F.
REQ-040 Same edge LK=1 LA=6 and RW=1 DA=6 -> PEND[6]=1 and R6=DD.
REQ-041 ZERO_R0=1: RW=1 DA=0 DD=16'hFFFF and LK=1 LA=0, then read AA=0 -> AD=0, AP=0, PEND[0]=0.
REQ-042 Write R1=16'h0001 and lock R4, then assert RESET mid-cycle -> AD, BD, PEND and RV are 0 immediately; a read of AA=1 after release returns 0.
